// File: rtl/param_pkg.sv
// Shared bus parameters for the AHB-lite response path.
package param_pkg;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
    parameter int NUM_SUBORD = 4;
endpackage

// File: rtl/response_mux.sv
// AHB-lite data-phase response multiplexer with a built-in default subordinate.
// Define RESPONSE_MUX_ERR_CNT_EN to add the Err_cnt default-subordinate error counter.
module response_mux
    import param_pkg::*;
(
    input  logic                                  Hclk,
    input  logic                                  Hreset,
    input  logic [NUM_SUBORD-1:0]                 Hsel,
    input  logic [1:0]                            Htrans,
    input  logic [NUM_SUBORD-1:0][DATA_WIDTH-1:0] Hrdata_s,
    input  logic [NUM_SUBORD-1:0]                 Hreadyout_s,
    input  logic [NUM_SUBORD-1:0]                 Hresp_s,
    output logic [DATA_WIDTH-1:0]                 Hrdata,
    output logic                                  Hready,
    output logic                                  Hresp
`ifdef RESPONSE_MUX_ERR_CNT_EN
    ,
    output logic [15:0]                           Err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SUBORD-1:0]   sel_q;
    logic                    def_q;
    logic [NUM_SUBORD-1:0]   sel_onehot;
    logic [NUM_SUBORD:0]     seen_lower;
    logic                    def_capture;
    logic                    fsm_ready, fsm_resp;
    logic [DATA_WIDTH-1:0]   mux_rdata;
    logic                    mux_ready, mux_resp;

    // Lowest-index priority: a bit survives only if no lower bit is set.
    assign seen_lower[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < NUM_SUBORD; gi++) begin : g_onehot
            assign sel_onehot[gi]   = Hsel[gi] & ~seen_lower[gi];
            assign seen_lower[gi+1] = seen_lower[gi] | Hsel[gi];
        end
    endgenerate

    assign def_capture = Hready & ~(|Hsel) & Htrans[1];

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            sel_q   <= '0;
            def_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            if (Hready) begin
                sel_q <= sel_onehot;
                def_q <= ~(|Hsel) & Htrans[1];
            end
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fsm_ready = 1'b1;
        fsm_resp  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (def_capture) state_d = ST_ERR1;
            end
            ST_ERR1: begin
                fsm_ready = 1'b0;
                fsm_resp  = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                fsm_resp = 1'b1;
                state_d  = def_capture ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // sel_q is one-hot or zero, so an AND-OR reduction is a clean mux.
    always_comb begin
        mux_rdata = '0;
        mux_ready = 1'b0;
        mux_resp  = 1'b0;
        for (int i = 0; i < NUM_SUBORD; i++) begin
            if (sel_q[i]) begin
                mux_rdata = mux_rdata | Hrdata_s[i];
                mux_ready = mux_ready | Hreadyout_s[i];
                mux_resp  = mux_resp  | Hresp_s[i];
            end
        end
    end

    assign Hrdata = mux_rdata;
    assign Hready = (|sel_q) ? mux_ready : fsm_ready;
    assign Hresp  = (|sel_q) ? mux_resp  : fsm_resp;

`ifdef RESPONSE_MUX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            err_cnt_q <= '0;
        end else if (state_q != ST_ERR1 && state_d == ST_ERR1 && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign Err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_response_mux.sv
// Directed-vector bench for response_mux; drives #1 after the edge, samples before the next.
module tb_response_mux;
    import param_pkg::*;

    logic                                  Hclk = 1'b0;
    logic                                  Hreset;
    logic [NUM_SUBORD-1:0]                 Hsel;
    logic [1:0]                            Htrans;
    logic [NUM_SUBORD-1:0][DATA_WIDTH-1:0] Hrdata_s;
    logic [NUM_SUBORD-1:0]                 Hreadyout_s;
    logic [NUM_SUBORD-1:0]                 Hresp_s;
    logic [DATA_WIDTH-1:0]                 Hrdata;
    logic                                  Hready;
    logic                                  Hresp;
`ifdef RESPONSE_MUX_ERR_CNT_EN
    logic [15:0]                           Err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    response_mux dut (
        .Hclk        (Hclk),
        .Hreset      (Hreset),
        .Hsel        (Hsel),
        .Htrans      (Htrans),
        .Hrdata_s    (Hrdata_s),
        .Hreadyout_s (Hreadyout_s),
        .Hresp_s     (Hresp_s),
        .Hrdata      (Hrdata),
        .Hready      (Hready),
        .Hresp       (Hresp)
`ifdef RESPONSE_MUX_ERR_CNT_EN
        ,
        .Err_cnt     (Err_cnt)
`endif
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic resp_chk(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
        check({tag, ".ready"}, {31'd0, Hready}, {31'd0, rdy});
        check({tag, ".resp"},  {31'd0, Hresp},  {31'd0, rsp});
        check({tag, ".rdata"}, Hrdata, rd);
    endtask

    initial begin
        Hreset      = 1'b1;
        Hsel        = 4'b0000;
        Htrans      = T_IDLE;
        Hrdata_s[0] = 32'hA5A5_0001;
        Hrdata_s[1] = 32'hB0B0_0002;
        Hrdata_s[2] = 32'hC0C0_0003;
        Hrdata_s[3] = 32'hD0D0_0004;
        Hreadyout_s = 4'b1111;
        Hresp_s     = 4'b0000;
        #2;
        step();
        step();
        Hreset = 1'b0;
        resp_chk("reset", 1'b1, 1'b0, 32'h0);
`ifdef RESPONSE_MUX_ERR_CNT_EN
        check("reset.err_cnt", {16'd0, Err_cnt}, 32'd0);
`endif

        // Basic read from subordinate 0, next address targets subordinate 1 (waits 3 cycles)
        Hsel = 4'b0001; Htrans = T_NONSEQ;
        step();
        resp_chk("s0_read", 1'b1, 1'b0, 32'hA5A5_0001);
        Hsel = 4'b0010; Htrans = T_NONSEQ; Hreadyout_s[1] = 1'b0;
        step();
        Hsel = 4'b0100;
        resp_chk("s1_wait1", 1'b0, 1'b0, 32'hB0B0_0002);
        step();
        resp_chk("s1_wait2", 1'b0, 1'b0, 32'hB0B0_0002);
        step();
        resp_chk("s1_wait3", 1'b0, 1'b0, 32'hB0B0_0002);
        Hreadyout_s[1] = 1'b1;
        #1;
        check("s1_done.ready", {31'd0, Hready}, 32'd1);
        step();
        resp_chk("s2_after_wait", 1'b1, 1'b0, 32'hC0C0_0003);

        // Multi-hot select: lowest index wins
        Hsel = 4'b0110; Htrans = T_SEQ;
        step();
        resp_chk("multihot", 1'b1, 1'b0, 32'hB0B0_0002);

        // Unmapped NONSEQ: two-cycle ERROR, then back to IDLE
        Hsel = 4'b0000; Htrans = T_NONSEQ;
        step();
        Htrans = T_IDLE;
        resp_chk("err1", 1'b0, 1'b1, 32'h0);
        step();
        resp_chk("err2", 1'b1, 1'b1, 32'h0);
`ifdef RESPONSE_MUX_ERR_CNT_EN
        check("err.err_cnt", {16'd0, Err_cnt}, 32'd1);
`endif
        step();
        resp_chk("err_to_idle", 1'b1, 1'b0, 32'h0);
        step();
        resp_chk("unmapped_idle", 1'b1, 1'b0, 32'h0);
        Htrans = T_BUSY;
        step();
        resp_chk("unmapped_busy", 1'b1, 1'b0, 32'h0);
`ifdef RESPONSE_MUX_ERR_CNT_EN
        check("idle.err_cnt", {16'd0, Err_cnt}, 32'd1);
`endif

        // Subordinate ERROR passes through unmodified
        Hsel = 4'b0001; Htrans = T_NONSEQ; Hresp_s[0] = 1'b1; Hreadyout_s[0] = 1'b0;
        step();
        Hsel = 4'b0000; Htrans = T_IDLE;
        resp_chk("sub_err1", 1'b0, 1'b1, 32'hA5A5_0001);
        Hreadyout_s[0] = 1'b1;
        #1;
        resp_chk("sub_err2", 1'b1, 1'b1, 32'hA5A5_0001);
        step();
        Hresp_s[0] = 1'b0;
        resp_chk("sub_err_done", 1'b1, 1'b0, 32'h0);

        // Back-to-back unmapped NONSEQ: ERR2 re-enters ERR1
        Hsel = 4'b0000; Htrans = T_NONSEQ;
        step();
        resp_chk("b2b_err1", 1'b0, 1'b1, 32'h0);
        step();
        resp_chk("b2b_err2", 1'b1, 1'b1, 32'h0);
        step();
        resp_chk("b2b_err1_again", 1'b0, 1'b1, 32'h0);
`ifdef RESPONSE_MUX_ERR_CNT_EN
        check("b2b.err_cnt", {16'd0, Err_cnt}, 32'd3);
`endif

        // Reset during ERR1 wins over a pending unmapped NONSEQ
        Hreset = 1'b1;
        step();
        Hreset = 1'b0; Htrans = T_IDLE;
        resp_chk("rst_in_err1", 1'b1, 1'b0, 32'h0);
`ifdef RESPONSE_MUX_ERR_CNT_EN
        check("rst.err_cnt", {16'd0, Err_cnt}, 32'd0);
`endif

        // Reset during a subordinate wait state
        Hsel = 4'b1000; Htrans = T_NONSEQ; Hreadyout_s[3] = 1'b0;
        step();
        Htrans = T_IDLE; Hsel = 4'b0000;
        resp_chk("s3_wait", 1'b0, 1'b0, 32'hD0D0_0004);
        Hreset = 1'b1;
        step();
        Hreset = 1'b0;
        resp_chk("rst_in_wait", 1'b1, 1'b0, 32'h0);
        Hreadyout_s[3] = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
